// File: rtl/cp0_regfile_pkg.sv
// cp0_defs: shared CP0 definitions for the MIPS core.
// Holds register addresses, ExcCode values, Status/Cause bit positions
// and the masks of the software-writable fields.
package cp0_defs;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } excode_e;

  localparam int unsigned ST_IE  = 0;
  localparam int unsigned ST_EXL = 1;
  localparam int unsigned ST_BEV = 22;
  localparam int unsigned CA_TI  = 30;
  localparam int unsigned CA_BD  = 31;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] STATUS_RO    = 32'h0040_0000;  // BEV reads as 1
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

endpackage

// File: rtl/cp0_regfile_if.sv
// cp0_regfile_if: MTC0/MFC0 access bus between decode/writeback and CP0.
//   we_i/waddr_i/wdata_i : MTC0 commit
//   raddr_i/rdata_o      : MFC0 read (combinational)
interface cp0_regfile_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;

  modport master (output we_i, waddr_i, wdata_i, raddr_i, input rdata_o);
  modport slave  (input we_i, waddr_i, wdata_i, raddr_i, output rdata_o);
endinterface

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer.
//   count_we/compare_we/wdata : register loads
//   count_o/compare_o         : register values
//   ti_o                      : sticky timer interrupt, cleared by a Compare load
// Count advances on every second cycle, paced by a free-running tick.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic        tick;
  logic [31:0] count_inc;

  assign count_inc = count_o + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick      <= 1'b0;
      count_o   <= '0;
      compare_o <= '0;
      ti_o      <= 1'b0;
    end else begin
      tick <= ~tick;
      if (count_we)
        count_o <= wdata;
      else if (tick)
        count_o <= count_inc;
      if (compare_we)
        compare_o <= wdata;
      // A Compare write beats a coincident match; a Count load never matches.
      if (compare_we)
        ti_o <= 1'b0;
      else if (tick && !count_we && count_inc == compare_o)
        ti_o <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// cp0_regfile: Coprocessor-0 register file and exception state.
//   clk, rst                     : clock, async active-high reset
//   bus (cp0_regfile_if.slave)   : MTC0 write / MFC0 read
//   int_i                        : hardware interrupt lines
//   exc_i, excode_i, pc_i, in_delayslot_i, badaddr_i : exception commit
//   eret_i                       : ERET commit
//   status_o, cause_o, epc_o     : register values
//   int_pending_o                : unmasked interrupt pending
module cp0_regfile
  import cp0_defs::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h0000_4220
) (
  input  logic          clk,
  input  logic          rst,
  cp0_regfile_if.slave  bus,
  input  logic [5:0]    int_i,
  input  logic          exc_i,
  input  logic [4:0]    excode_i,
  input  logic          eret_i,
  input  logic [31:0]   pc_i,
  input  logic          in_delayslot_i,
  input  logic [31:0]   badaddr_i,
  output logic [31:0]   status_o,
  output logic [31:0]   cause_o,
  output logic [31:0]   epc_o,
  output logic          int_pending_o
);

  logic [7:0]  im;
  logic        exl, ie, bd;
  logic [5:0]  ip_hw;
  logic [1:0]  ip_sw;
  logic [4:0]  exccode;
  logic [31:0] epc, badvaddr;
  logic [31:0] count, compare;
  logic        ti;
  logic        wr;
  logic [31:0] rd_reg;

  // MTC0 loses to an exception or ERET in the same cycle.
  assign wr = bus.we_i & ~exc_i & ~eret_i;

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (wr && bus.waddr_i == CP0_COUNT),
    .compare_we (wr && bus.waddr_i == CP0_COMPARE),
    .wdata      (bus.wdata_i),
    .count_o    (count),
    .compare_o  (compare),
    .ti_o       (ti)
  );

  assign status_o      = STATUS_RO | {16'h0000, im, 6'b000000, exl, ie};
  assign cause_o       = {bd, ti, 14'h0000, ip_hw, ip_sw, 1'b0, exccode, 2'b00};
  assign epc_o         = epc;
  assign int_pending_o = ie & ~exl & (|(cause_o[15:8] & im));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip_hw    <= '0;
      ip_sw    <= '0;
      exccode  <= '0;
      epc      <= '0;
      badvaddr <= '0;
    end else begin
      ip_hw <= {int_i[5] | ti, int_i[4:0]};
      if (exc_i) begin
        exccode <= excode_i;
        exl     <= 1'b1;
        // Nested exceptions keep the original return point.
        if (!exl) begin
          epc <= in_delayslot_i ? pc_i - 32'd4 : pc_i;
          bd  <= in_delayslot_i;
        end
        if (excode_i == EXC_ADEL || excode_i == EXC_ADES)
          badvaddr <= badaddr_i;
      end else if (eret_i) begin
        exl <= 1'b0;
      end else if (bus.we_i) begin
        case (bus.waddr_i)
          CP0_STATUS: begin
            im  <= bus.wdata_i[15:8];
            exl <= bus.wdata_i[ST_EXL];
            ie  <= bus.wdata_i[ST_IE];
          end
          CP0_CAUSE: ip_sw <= bus.wdata_i[9:8];
          CP0_EPC:   epc   <= bus.wdata_i;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_reg = '0;
    case (bus.raddr_i)
      CP0_BADVADDR: rd_reg = badvaddr;
      CP0_COUNT:    rd_reg = count;
      CP0_COMPARE:  rd_reg = compare;
      CP0_STATUS:   rd_reg = status_o;
      CP0_CAUSE:    rd_reg = cause_o;
      CP0_EPC:      rd_reg = epc;
      CP0_PRID:     rd_reg = PRID_VALUE;
      default:      rd_reg = '0;
    endcase
  end

  // Same-cycle MTC0 to the read address forwards the value being written.
  always_comb begin
    bus.rdata_o = rd_reg;
    if (wr && bus.waddr_i == bus.raddr_i) begin
      case (bus.waddr_i)
        CP0_COUNT, CP0_COMPARE, CP0_EPC: bus.rdata_o = bus.wdata_i;
        CP0_STATUS: bus.rdata_o = (bus.wdata_i & STATUS_WMASK) | STATUS_RO;
        CP0_CAUSE:  bus.rdata_o = (cause_o & ~CAUSE_WMASK) | (bus.wdata_i & CAUSE_WMASK);
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cp0_regfile.md
# cp0_regfile

Coprocessor-0 register file and exception state holder for the five-stage MIPS core. It answers the `cp0_we`/`cp0_re` requests produced by instruction decode (MTC0 writes, MFC0 reads) and records exception and ERET side effects committed at the memory stage. It also runs the Count/Compare timer and presents the interrupt-pending condition to the exception unit.

## Interface
- `PRID_VALUE`, default 32'h0000_4220: read-only value of PRId (reg 15).
- `clk`  in  1: core clock.
- `rst`  in  1: asynchronous, active-high reset.
- `we_i`  in  1: MTC0 commit (decode `cp0_we` carried to writeback).
- `waddr_i`  in  5: MTC0 destination (`rd` field).
- `wdata_i`  in  32: MTC0 data (`rt` value).
- `raddr_i`  in  5: MFC0 source (`rd` field).
- `rdata_o`  out  32: MFC0 read data.
- `int_i`  in  6: external hardware interrupt lines, level sensitive.
- `exc_i`  in  1: exception taken this cycle.
- `excode_i`  in  5: ExcCode for `exc_i`.
- `eret_i`  in  1: ERET committed this cycle.
- `pc_i`  in  32: PC of the excepting instruction.
- `in_delayslot_i`  in  1: the excepting instruction is in a branch delay slot.
- `badaddr_i`  in  32: faulting address for AdEL/AdES.
- `status_o`, `cause_o`, `epc_o`  out  32 each: current register values.
- `int_pending_o`  out  1: unmasked interrupt pending.

## Operation
- **Registers and addresses:** BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14, PRId 15. Reads of any other address return 0. Writes to any other address are ignored.
- **Writable fields:**
  - Status: IM [15:8], EXL [1], IE [0]. BEV [22] reads constant 1. All other bits read 0.
  - Cause: IP[1:0] at [9:8] only.
  - Count, Compare, EPC: all 32 bits.
  - BadVAddr, PRId: read-only.
- **Cause bits updated every cycle:**
  - IP[7:2] ([15:10]) <= {int_i[5] | TI, int_i[4:0]}.
  - TI is bit [30].
  - BD [31] and ExcCode [6:2] change only on exceptions.
- **Timer:**
  - A 1-bit `tick` toggles every cycle.
  - Count increments when `tick`==1, i.e. every second cycle. It wraps from FFFF_FFFF to 0.
  - TI sets on the increment whose new Count equals Compare. TI is sticky.
  - A write to Compare clears TI.
  - A write to Count loads the value and does not set TI.
- **Exception (`exc_i`):**
  - ExcCode <= `excode_i`.
  - Status.EXL <= 1.
  - If the old EXL was 0: EPC <= `in_delayslot_i` ? `pc_i`-4 : `pc_i`, and BD <= `in_delayslot_i`.
  - If the old EXL was 1: EPC and BD are unchanged.
  - If excode is AdEL (4) or AdES (5): BadVAddr <= `badaddr_i`.
- **ERET (`eret_i`):** Status.EXL <= 0.
- **Priority:**
  - `exc_i` > `eret_i` > `we_i`.
  - An MTC0 in the same cycle as an exception or ERET is dropped.
  - An MTC0 write to Count wins over that cycle's increment.
- **Read path:** `rdata_o` is combinational. If `we_i` && `waddr_i`==`raddr_i`, it returns the value that will be written (masked to writable fields, merged with read-only bits). Otherwise it returns the register value.
- **Interrupt pending:** `int_pending_o` = IE & ~EXL & |(Cause[15:8] & Status[15:8]). Computed combinationally from register state.

## Timing
- **Reset values:**
  - Status = 0040_0000.
  - Cause, EPC, Count, Compare, BadVAddr = 0.
  - `tick` = 0, TI = 0.
  - `int_pending_o` = 0.
- **Reset mid-operation:** all state returns to reset values immediately. The first Count increment occurs on the second rising edge after reset deasserts.
- **Latency:**
  - Writes and exception updates are visible in `status_o`/`cause_o`/`epc_o` one cycle after the edge.
  - MFC0 in the same cycle as a matching MTC0 sees the new value (0-cycle forward).
- **Interrupt sampling:** `int_i` change -> IP visible one cycle later -> `int_pending_o` high in that same cycle if unmasked.
- **Timer match:** TI set and the compare write clear are both registered. A Compare write and a matching increment in the same cycle: the clear wins, TI = 0.

## Structure
- Shared package `cp0_defs`:
  - register address constants (`CP0_BADVADDR`…`CP0_PRID`);
  - ExcCode constants (INT 0, ADEL 4, ADES 5, SYS 8, BP 9, RI 10, OV 12);
  - Status/Cause bit-position constants;
  - writable-mask constants.
- One natural sub-module: `cp0_timer`, holding Count, Compare, `tick` and TI, with a load/clear interface.

## Test plan
- **Reset and read-only:** reset, MFC0 Status -> 0040_0000. MTC0 Status FFFF_FFFF, then read -> 0040_FF03. MTC0 PRId, then read -> 0000_4220.
- **Timer:** MTC0 Compare 5, Count 0 -> TI set after 10 cycles. `int_pending_o`=1 with Status 0000_8001. MTC0 Compare 9 -> TI cleared next cycle.
- **Exception:**
  - `exc_i` excode 4, `pc_i` BFC0_0100, delay slot 1, `badaddr_i` 1234_5671 -> EPC BFC0_00FC, BD=1, ExcCode 4, BadVAddr 1234_5671, EXL=1.
  - A second exception with pc 0000_0040 -> EPC unchanged.
- **ERET and collision:** `eret_i` -> EXL=0. `exc_i` together with MTC0 EPC 0 -> MTC0 dropped, EPC = exception value.
- **Forwarding and interrupt:** MTC0 EPC DEAD_BEEF with MFC0 EPC in the same cycle -> `rdata_o` DEAD_BEEF. `int_i`=6'b000100 with IM bit 12 set, IE=1 -> `int_pending_o`=1 one cycle later.
- **Count wrap:** load Count FFFF_FFFF -> 0 after 2 cycles. No TI when Compare = 1.
